// File: rtl/lw_sha_pkg.sv
// Shared definitions for the lw_hmac host driver: FSM states, opcode fields,
// and the digest length helper.
package lw_sha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_KEY,
    ST_DATA,
    ST_WAIT,
    ST_DRAIN,
    ST_ABORT
  } drv_state_e;

  localparam int OP_HMAC_BIT = 1;
  localparam int OP_224_BIT  = 0;

  // SHA-224 truncates the final state to seven words.
  function automatic logic [3:0] digest_words(input logic [1:0] opcode);
    return opcode[OP_224_BIT] ? 4'd7 : 4'd8;
  endfunction

endpackage

// File: rtl/lw_digest_serializer.sv
// Captures the core's eight-word hash and replays it, highest index first,
// as a ready/valid word stream of 7 or 8 words.
module lw_digest_serializer
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   capture_i,
  input  logic [8*WORD_SIZE-1:0] hash_i,
  input  logic [3:0]             words_i,
  input  logic                   drain_i,
  input  logic                   dig_ready_i,
  output logic                   dig_valid_o,
  output logic [WORD_SIZE-1:0]   dig_data_o,
  output logic                   dig_last_o,
  output logic                   done_o
);

  logic [7:0][WORD_SIZE-1:0] word_q;
  logic [2:0]                idx_q;
  logic [3:0]                last_diff;
  logic [2:0]                last_idx;

  assign last_diff = 4'd8 - words_i;
  assign last_idx  = last_diff[2:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (capture_i) begin
      word_q <= hash_i;
      idx_q  <= 3'd7;
    end else if (drain_i && dig_ready_i) begin
      idx_q <= idx_q - 3'd1;
    end
  end

  assign dig_valid_o = drain_i;
  assign dig_data_o  = drain_i ? word_q[idx_q] : '0;
  assign dig_last_o  = drain_i && (idx_q == last_idx);
  assign done_o      = dig_last_o && dig_ready_i;

endmodule

// File: rtl/lw_hmac_driver.sv
// Host-side initiator for the lw_hmac core: sequences start/key/data into the
// core, returns the digest as a word stream, and aborts a hung core.
module lw_hmac_driver
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int KEY_WORDS = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_opcode_i,
  input  logic                   cmd_new_key_i,
  input  logic                   key_valid_i,
  input  logic [WORD_SIZE-1:0]   key_data_i,
  output logic                   key_ready_o,
  input  logic                   msg_valid_i,
  input  logic [WORD_SIZE-1:0]   msg_data_i,
  input  logic                   msg_last_i,
  output logic                   msg_ready_o,
  output logic                   dig_valid_o,
  output logic [WORD_SIZE-1:0]   dig_data_o,
  output logic                   dig_last_o,
  input  logic                   dig_ready_i,
  output logic                   err_timeout_o,
  output logic                   core_start_o,
  output logic                   core_data_valid_o,
  output logic                   core_last_o,
  output logic                   core_key_valid_o,
  output logic                   core_new_key_o,
  output logic                   core_abort_o,
  output logic [1:0]             core_opcode_o,
  output logic [WORD_SIZE-1:0]   core_data_o,
  output logic [WORD_SIZE-1:0]   core_key_o,
  input  logic                   core_ready_i,
  input  logic                   core_key_ready_i,
  input  logic                   core_idle_i,
  input  logic                   core_done_i,
  input  logic [8*WORD_SIZE-1:0] core_hash_i
);

  localparam int KCW = $clog2(KEY_WORDS + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  drv_state_e     state_q, state_d;
  logic [1:0]     opcode_q;
  logic           new_key_q;
  logic [KCW-1:0] key_cnt_q;
  logic [WDW-1:0] wd_cnt_q;
  logic           err_q;
  logic           cmd_hs, key_hs, msg_hs, capture, drain_done, watched, timed_out;

  always_comb begin
    state_d           = state_q;
    cmd_ready_o       = 1'b0;
    key_ready_o       = 1'b0;
    msg_ready_o       = 1'b0;
    core_start_o      = 1'b0;
    core_data_valid_o = 1'b0;
    core_last_o       = 1'b0;
    core_key_valid_o  = 1'b0;
    core_new_key_o    = 1'b0;
    core_abort_o      = 1'b0;
    core_opcode_o     = '0;
    core_data_o       = '0;
    core_key_o        = '0;
    cmd_hs            = 1'b0;
    key_hs            = 1'b0;
    msg_hs            = 1'b0;
    capture           = 1'b0;
    timed_out         = 1'b0;
    watched           = (state_q == ST_KEY) || (state_q == ST_DATA) || (state_q == ST_WAIT);
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = core_idle_i;
        if (cmd_valid_i && core_idle_i) begin
          cmd_hs  = 1'b1;
          state_d = ST_START;
        end
      end
      // The core leaves idle on start && data_valid; the word is not consumed here.
      ST_START: begin
        if (msg_valid_i) begin
          core_start_o      = 1'b1;
          core_data_valid_o = 1'b1;
          core_data_o       = msg_data_i;
          core_opcode_o     = opcode_q;
          core_new_key_o    = new_key_q;
          state_d = (opcode_q[OP_HMAC_BIT] && new_key_q) ? ST_KEY : ST_DATA;
        end
      end
      ST_KEY: begin
        core_key_valid_o = key_valid_i;
        core_key_o       = key_data_i;
        key_ready_o      = core_key_ready_i;
        key_hs           = key_valid_i && core_key_ready_i;
        if (key_hs && key_cnt_q == KCW'(KEY_WORDS - 1)) state_d = ST_DATA;
      end
      ST_DATA: begin
        core_data_valid_o = msg_valid_i;
        core_data_o       = msg_data_i;
        core_last_o       = msg_last_i;
        msg_ready_o       = core_ready_i;
        msg_hs            = msg_valid_i && core_ready_i;
        if (msg_hs && msg_last_i) begin
          capture = core_done_i;
          state_d = core_done_i ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done_i) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        core_abort_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (watched && state_d == state_q && !key_hs && !msg_hs &&
        wd_cnt_q == WDW'(TIMEOUT - 1)) begin
      timed_out = 1'b1;
      state_d   = ST_ABORT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      new_key_q <= 1'b0;
      key_cnt_q <= '0;
      wd_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        opcode_q  <= cmd_opcode_i;
        new_key_q <= cmd_new_key_i;
        err_q     <= 1'b0;
      end
      if (state_q == ST_START) key_cnt_q <= '0;
      else if (key_hs)         key_cnt_q <= key_cnt_q + KCW'(1);
      // Idle-cycle count since the last handshake or state change.
      if (watched && !key_hs && !msg_hs && state_d == state_q) wd_cnt_q <= wd_cnt_q + WDW'(1);
      else                                                     wd_cnt_q <= '0;
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign err_timeout_o = err_q;

  lw_digest_serializer #(.WORD_SIZE(WORD_SIZE)) u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .capture_i   (capture),
    .hash_i      (core_hash_i),
    .words_i     (digest_words(opcode_q)),
    .drain_i     (state_q == ST_DRAIN),
    .dig_ready_i (dig_ready_i),
    .dig_valid_o (dig_valid_o),
    .dig_data_o  (dig_data_o),
    .dig_last_o  (dig_last_o),
    .done_o      (drain_done)
  );

endmodule
